ram_bist: RTL
=============

Name: ram_bist

Overview:
- Synthesizable initiator for the single-port 1Kx8 RAM (data_out, data_in, address, write, select).
- On start, writes a deterministic pattern to every address, then reads every address back and compares.
- Reports pass/fail, error count and first failing address.
- Sits between the system controller and the RAM; it is the driving end of the RAM's write/select interface.

Parameters:
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- STEP, 2, pattern multiplier: expected(a) = (a*STEP + SEED) mod 2**DATA_W.
- SEED, 0, pattern offset.
- ERR_W, 11, error counter width; counter saturates.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- abort  in  1  cancels a running test.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high in DONE until the next start, abort or reset.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  ERR_W  number of mismatching reads, saturating at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- mem_address  out  ADDR_W  RAM address.
- mem_data_in  out  DATA_W  RAM write data.
- mem_data_out  in  DATA_W  RAM read data.
- mem_write  out  1  RAM write enable.
- mem_select  out  1  RAM chip select.

Behaviour:
- Interface: clock is clk; reset is synchronous, active-low (rst_n). No other clocks.
- Reset, and rst_n low at any time including mid-test:
  - Next edge puts the FSM in IDLE.
  - All outputs go to 0: busy, done, pass, err_count, first_err_addr, mem_address, mem_data_in, mem_write, mem_select.
- All outputs are registered.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE with start=1 at edge E (cycle 0):
  - Go to WRITE.
  - Clear err_count, first_err_addr, pass and done.
  - Set addr counter to 0.
- WRITE, cycles 1..2**ADDR_W:
  - mem_select=1, mem_write=1, mem_address=a, mem_data_in=expected(a).
  - a increments each cycle.
  - After a = 2**ADDR_W-1, go to READ with a=0 (counter wraps; wrap is the transition condition).
- READ, cycles 2**ADDR_W+1..2*2**ADDR_W:
  - mem_select=1, mem_write=0, mem_address=a.
  - Expected value and address are piped one stage.
  - mem_data_out is sampled one cycle after the address is issued and compared to the piped expected value.
  - After issuing the last address, go to DRAIN.
- DRAIN, one cycle:
  - mem_select=0, mem_write=0.
  - Compare the last read.
  - Go to DONE.
- DONE, from cycle 2*2**ADDR_W+2:
  - done=1, busy=0, pass=(err_count==0).
  - Memory signals idle (select=0, write=0, address/data hold 0).
- Mismatch handling:
  - err_count increments, saturating at 2**ERR_W-1.
  - first_err_addr is loaded only on the first mismatch of the run.
- start while busy: ignored.
- start and abort together in IDLE/DONE: abort wins, stay in or return to IDLE.
- abort while busy:
  - Next edge goes to IDLE.
  - mem_select=0, mem_write=0, busy=0, done=0, pass=0.
  - err_count and first_err_addr hold their last values.
- Pattern arithmetic: a*STEP+SEED is computed at ADDR_W+DATA_W bits, then truncated to DATA_W (mod 256 by default).
- Latency with defaults: start sampled → done=1 after 2050 clocks.

Decomposition:
- Package ram_bist_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE)
  - default ADDR_W/DATA_W/ERR_W constants
  - function expected_data(addr, step, seed)
- Sub-module ram_bist_patgen: combinational address→expected-data generator plus one-stage expected/address pipeline register for the read compare.
- FSM, counters and result registers live in ram_bist.

Test Plan:
- Clean RAM, STEP=2, SEED=0, start pulse → 1024 writes with data (2a)%256 (a=5 gives 10, a=200 gives 144), 1024 reads; done=1 at cycle 2050; pass=1; err_count=0; first_err_addr=0.
- RAM model with data bit 3 stuck-at-0 → addresses whose expected value has bit 3 set mismatch: err_count=512, first_err_addr=4, pass=0.
- RAM model corrupting only address 1023 → err_count=1, first_err_addr=1023. This checks that the DRAIN compare is not lost.
- Abort asserted at cycle 600 (mid-WRITE) → next cycle IDLE, busy=0, mem_select=0, done=0. A subsequent start completes normally with pass=1.
- rst_n low for one cycle during READ (cycle 1500) → next edge all outputs 0, state IDLE. A second start after reset gives a full clean run.
- start pulsed again at cycle 100 while busy → ignored, done still at cycle 2050. Start in DONE restarts and clears done/pass/err_count next cycle.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types, default widths and the address-to-pattern rule for the RAM BIST.
package ram_bist_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ERR_W  = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Caller truncates the result to the RAM data width.
  function automatic logic [31:0] expected_data(input logic [31:0] addr,
                                                input logic [31:0] step,
                                                input logic [31:0] seed);
    return addr * step + seed;
  endfunction

endpackage

// File: rtl/ram_bist_patgen.sv
// Pattern generator: expected data for the write address, plus a one-stage
// expected/address pipeline aligned with the RAM's synchronous read data.
module ram_bist_patgen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STEP   = 2,
  parameter int SEED   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] gen_addr_i,
  output logic [DATA_W-1:0] exp_data_o,
  input  logic              rd_valid_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              pipe_valid_o,
  output logic [ADDR_W-1:0] pipe_addr_o,
  output logic [DATA_W-1:0] pipe_data_o
);

  logic              pipe_valid_d, pipe_valid_q;
  logic [ADDR_W-1:0] pipe_addr_d, pipe_addr_q;
  logic [DATA_W-1:0] pipe_data_d, pipe_data_q;

  always_comb begin
    exp_data_o   = DATA_W'(expected_data(32'(gen_addr_i), 32'(STEP), 32'(SEED)));
    pipe_valid_d = rd_valid_i;
    pipe_addr_d  = rd_addr_i;
    pipe_data_d  = DATA_W'(expected_data(32'(rd_addr_i), 32'(STEP), 32'(SEED)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid_q <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_data_q  <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  assign pipe_valid_o = pipe_valid_q;
  assign pipe_addr_o  = pipe_addr_q;
  assign pipe_data_o  = pipe_data_q;

endmodule

// File: rtl/ram_bist.sv
// RAM BIST initiator: writes a deterministic pattern to every address, reads
// it back through a synchronous-read RAM and reports pass/fail statistics.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STEP   = 2,
  parameter int SEED   = 0,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write,
  output logic              mem_select
);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              pass_d, pass_q;
  logic [ERR_W-1:0]  err_d, err_q;
  logic [ADDR_W-1:0] first_d, first_q;
  logic [ADDR_W-1:0] mem_address_d, mem_address_q;
  logic [DATA_W-1:0] mem_data_in_d, mem_data_in_q;
  logic              mem_write_d, mem_write_q;
  logic              mem_select_d, mem_select_q;

  logic              rd_valid;
  logic [DATA_W-1:0] exp_data;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;

  ram_bist_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .SEED   (SEED)
  ) u_patgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .gen_addr_i   (addr_q),
    .exp_data_o   (exp_data),
    .rd_valid_i   (rd_valid),
    .rd_addr_i    (mem_address_q),
    .pipe_valid_o (pipe_valid),
    .pipe_addr_o  (pipe_addr),
    .pipe_data_o  (pipe_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    err_d         = err_q;
    first_d       = first_q;
    mem_address_d = '0;
    mem_data_in_d = '0;
    mem_write_d   = 1'b0;
    mem_select_d  = 1'b0;
    rd_valid      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      // The piped compare runs on the edge after each read address was captured.
      if (pipe_valid && (pipe_data != mem_data_out)) begin
        if (err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
        if (err_q == '0) begin
          first_d = pipe_addr;
        end
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d       = ST_WRITE;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            err_d         = '0;
            first_d       = '0;
            mem_select_d  = 1'b1;
            mem_write_d   = 1'b1;
            mem_address_d = addr_q;
            mem_data_in_d = exp_data;
            addr_d        = addr_q + ADDR_W'(1);
          end
        end

        ST_WRITE: begin
          mem_select_d  = 1'b1;
          mem_address_d = addr_q;
          addr_d        = addr_q + ADDR_W'(1);
          if (addr_q == '0) begin
            state_d = ST_READ;
          end else begin
            mem_write_d   = 1'b1;
            mem_data_in_d = exp_data;
          end
        end

        ST_READ: begin
          rd_valid = 1'b1;
          if (addr_q == '0) begin
            state_d = ST_DRAIN;
          end else begin
            mem_select_d  = 1'b1;
            mem_address_d = addr_q;
            addr_d        = addr_q + ADDR_W'(1);
          end
        end

        ST_DRAIN: begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end

        default: begin
          state_d = ST_IDLE;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      first_q       <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_write_q   <= 1'b0;
      mem_select_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      first_q       <= first_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      mem_select_q  <= mem_select_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign mem_address    = mem_address_q;
  assign mem_data_in    = mem_data_in_q;
  assign mem_write      = mem_write_q;
  assign mem_select     = mem_select_q;

endmodule
